// File: rtl/node_info_ctrl.sv
// EER-RL per-node info/phase controller: HB-locked clustering FSM, Q/energy latches, debounced low_E, TDMA tx window.
// All packet effects land one cycle after en_MNI; tx_window is combinational from registers; no backpressure (en_MNI always accepted).
module node_info_ctrl #(
  parameter int                WORD_W       = 16,
  parameter logic [WORD_W-1:0] NODE_ID      = 16'h000C,
  parameter int                HB_TIMEOUT   = 1024,
  parameter int                SLOT_LEN     = 64,
  parameter int                E_HYST       = 16,
  parameter int                LOWE_CONFIRM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_MNI,
  input  logic [2:0]        fPktType,
  input  logic [WORD_W-1:0] destinationID,
  input  logic [WORD_W-1:0] hops,
  input  logic [WORD_W-1:0] e_threshold,
  input  logic [WORD_W-1:0] timeslot,
  input  logic [WORD_W-1:0] energy,
  input  logic              e_sample,
  input  logic              q_valid,
  input  logic [WORD_W-1:0] q_value,
  input  logic              frame_start,
  output logic [WORD_W-1:0] myNodeID,
  output logic [WORD_W-1:0] hopsFromSink,
  output logic [WORD_W-1:0] eThreshold,
  output logic [WORD_W-1:0] myQValue,
  output logic              role,
  output logic              low_E,
  output logic              hb_lock,
  output logic [1:0]        phase,
  output logic [WORD_W-1:0] my_slot,
  output logic              tx_window,
  output logic              recluster_req
);

  localparam logic [1:0] S_UNCLUST = 2'b00;
  localparam logic [1:0] S_CLUSTER = 2'b01;
  localparam logic [1:0] S_COMM    = 2'b10;
  localparam logic [1:0] S_RECLUST = 2'b11;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHE  = 3'b001;
  localparam logic [2:0] PKT_TS   = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;
  localparam logic [2:0] PKT_SOS  = 3'b110;

  localparam int TO_W  = $clog2(HB_TIMEOUT);
  localparam int CYC_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int CNF_W = $clog2(LOWE_CONFIRM + 1);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(HB_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_LEN - 1);
  localparam logic [CNF_W-1:0] CNF_MAX  = CNF_W'(LOWE_CONFIRM);

  logic [1:0]        phase_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [WORD_W-1:0] slot_idx;
  logic [CNF_W-1:0]  cnf_cnt;
  logic [CNF_W-1:0]  cnf_inc;
  logic [WORD_W:0]   hi_sum;
  logic [WORD_W-1:0] hi_thr;
  logic              slot_valid;
  logic              frame_active;
  logic              to_me;
  logic              hb_pkt, che_pkt, ts_pkt, data_pkt, sos_pkt;
  logic              hb_accept, below_thr, low_set;

  always_comb begin
    to_me     = (destinationID == NODE_ID);
    hb_pkt    = en_MNI && (fPktType == PKT_HB);
    che_pkt   = en_MNI && (fPktType == PKT_CHE);
    ts_pkt    = en_MNI && (fPktType == PKT_TS);
    data_pkt  = en_MNI && (fPktType == PKT_DATA);
    sos_pkt   = en_MNI && (fPktType == PKT_SOS);
    hb_accept = hb_pkt && ((phase == S_UNCLUST) || (phase == S_RECLUST));

    phase_nxt = phase;
    case (phase)
      S_UNCLUST: if (hb_pkt) phase_nxt = S_CLUSTER;
      // data on the expiry cycle still takes the node into S_COMM
      S_CLUSTER: begin
        if (data_pkt)               phase_nxt = S_COMM;
        else if (to_cnt == TO_LAST) phase_nxt = S_UNCLUST;
      end
      S_COMM:    if (sos_pkt) phase_nxt = S_RECLUST;
      default:   if (hb_pkt) phase_nxt = S_CLUSTER;
    endcase

    // release bound saturates rather than wrapping past all-ones
    hi_sum    = {1'b0, eThreshold} + (WORD_W + 1)'(E_HYST);
    hi_thr    = hi_sum[WORD_W] ? '1 : hi_sum[WORD_W-1:0];
    below_thr = (energy < eThreshold);
    cnf_inc   = (cnf_cnt == CNF_MAX) ? cnf_cnt : cnf_cnt + CNF_W'(1);
    low_set   = e_sample && below_thr && (cnf_inc == CNF_MAX) && !low_E;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= S_UNCLUST;
      to_cnt        <= '0;
      hopsFromSink  <= '0;
      eThreshold    <= '0;
      myQValue      <= '0;
      role          <= 1'b0;
      low_E         <= 1'b0;
      hb_lock       <= 1'b0;
      my_slot       <= '0;
      slot_valid    <= 1'b0;
      recluster_req <= 1'b0;
      cnf_cnt       <= '0;
      frame_active  <= 1'b0;
      cyc_cnt       <= '0;
      slot_idx      <= '0;
    end else begin
      phase <= phase_nxt;
      if (phase_nxt != phase)     to_cnt <= '0;
      else if (phase == S_CLUSTER) to_cnt <= to_cnt + TO_W'(1);

      if (hb_accept) begin
        hopsFromSink <= hops;
        eThreshold   <= e_threshold;
        role         <= 1'b0;
        slot_valid   <= 1'b0;
        hb_lock      <= 1'b1;
      end

      if (phase == S_CLUSTER) begin
        if (che_pkt && to_me) role <= 1'b1;
        if (ts_pkt && to_me && !role) begin
          my_slot    <= timeslot;
          slot_valid <= 1'b1;
        end
        if (phase_nxt != S_CLUSTER) hb_lock <= 1'b0;
      end

      if (q_valid) myQValue <= q_value;

      recluster_req <= low_set && role;
      if (e_sample) begin
        if (below_thr) begin
          cnf_cnt <= cnf_inc;
          if (cnf_inc == CNF_MAX) low_E <= 1'b1;
        end else begin
          cnf_cnt <= '0;
          if (energy >= hi_thr) low_E <= 1'b0;
        end
      end

      if ((phase == S_COMM) && frame_start) begin
        frame_active <= 1'b1;
        cyc_cnt      <= '0;
        slot_idx     <= '0;
      end else if (frame_active) begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_cnt <= '0;
          if (slot_idx != '1) slot_idx <= slot_idx + WORD_W'(1);
        end else begin
          cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
      end
      if (phase_nxt != S_COMM) frame_active <= 1'b0;
    end
  end

  assign myNodeID  = NODE_ID;
  assign tx_window = frame_active && slot_valid && !role && (phase == S_COMM) && (slot_idx == my_slot);

endmodule

// File: tb/tb_node_info_ctrl.sv
// Directed bench for node_info_ctrl: FSM, HB lock/timeout, low_E hysteresis, TDMA window, reset.
module tb_node_info_ctrl;

  localparam int W  = 16;
  localparam int TO = 1024;

  localparam logic [2:0] HB = 3'b000, CHE = 3'b001, TS = 3'b100, DATA = 3'b101, SOS = 3'b110;

  logic         clk = 1'b0;
  logic         rst;
  logic         en_MNI;
  logic [2:0]   fPktType;
  logic [W-1:0] destinationID, hops, e_threshold, timeslot, energy, q_value;
  logic         e_sample, q_valid, frame_start;
  logic [W-1:0] myNodeID, hopsFromSink, eThreshold, myQValue, my_slot;
  logic         role, low_E, hb_lock, tx_window, recluster_req;
  logic [1:0]   phase;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  node_info_ctrl #(
    .WORD_W(W), .NODE_ID(16'h000C), .HB_TIMEOUT(TO),
    .SLOT_LEN(64), .E_HYST(16), .LOWE_CONFIRM(4)
  ) dut (
    .clk(clk), .rst(rst), .en_MNI(en_MNI), .fPktType(fPktType),
    .destinationID(destinationID), .hops(hops), .e_threshold(e_threshold),
    .timeslot(timeslot), .energy(energy), .e_sample(e_sample),
    .q_valid(q_valid), .q_value(q_value), .frame_start(frame_start),
    .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .eThreshold(eThreshold),
    .myQValue(myQValue), .role(role), .low_E(low_E), .hb_lock(hb_lock),
    .phase(phase), .my_slot(my_slot), .tx_window(tx_window),
    .recluster_req(recluster_req)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] t, input logic [W-1:0] dest, input logic [W-1:0] v);
    en_MNI        = 1'b1;
    fPktType      = t;
    destinationID = dest;
    hops          = v;
    timeslot      = v;
    tick();
    en_MNI = 1'b0;
  endtask

  task automatic sample(input logic [W-1:0] e);
    energy   = e;
    e_sample = 1'b1;
    tick();
    e_sample = 1'b0;
  endtask

  initial begin
    int first, last, cnt;
    rst = 1'b1; en_MNI = 1'b0; fPktType = 3'b111; destinationID = '0; hops = '0;
    e_threshold = 16'd100; timeslot = '0; energy = '0; e_sample = 1'b0;
    q_valid = 1'b0; q_value = '0; frame_start = 1'b0;
    tick(); tick();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_hb_lock", 32'(hb_lock), 32'd0);
    chk("rst_hops", 32'(hopsFromSink), 32'd0);
    chk("node_id", 32'(myNodeID), 32'h000C);
    rst = 1'b0;
    tick();

    // HB accept, then second HB ignored
    send(HB, 16'h0000, 16'd3);
    chk("hb_hops", 32'(hopsFromSink), 32'd3);
    chk("hb_thr", 32'(eThreshold), 32'd100);
    chk("hb_lock_set", 32'(hb_lock), 32'd1);
    chk("hb_phase", 32'(phase), 32'd1);
    send(HB, 16'h0000, 16'd7);
    chk("hb2_ignored", 32'(hopsFromSink), 32'd3);

    // CHE: wrong dest ignored, own dest makes CH
    send(CHE, 16'h0005, 16'd0);
    chk("che_other", 32'(role), 32'd0);
    send(CHE, 16'h000C, 16'd0);
    chk("che_me", 32'(role), 32'd1);
    send(DATA, 16'h0000, 16'd0);
    chk("data_phase", 32'(phase), 32'd2);
    chk("data_unlock", 32'(hb_lock), 32'd0);

    q_value = 16'h1234; q_valid = 1'b1; tick(); q_valid = 1'b0;
    chk("q_latch", 32'(myQValue), 32'h1234);

    // low_E debounce / hysteresis, eThreshold=100, CH role
    sample(16'd90); sample(16'd90); sample(16'd90);
    chk("lowe_3", 32'(low_E), 32'd0);
    sample(16'd90);
    chk("lowe_4", 32'(low_E), 32'd1);
    chk("recl_pulse", 32'(recluster_req), 32'd1);
    tick();
    chk("recl_one", 32'(recluster_req), 32'd0);
    sample(16'd110);
    chk("lowe_hold", 32'(low_E), 32'd1);
    sample(16'd116);
    chk("lowe_clr", 32'(low_E), 32'd0);
    sample(16'd90); sample(16'd90); sample(16'd105); sample(16'd90);
    chk("lowe_broken", 32'(low_E), 32'd0);
    chk("recl_none", 32'(recluster_req), 32'd0);

    // SOS -> reclust, HB re-accepted
    send(SOS, 16'h0000, 16'd0);
    chk("sos_phase", 32'(phase), 32'd3);
    send(HB, 16'h0000, 16'd5);
    chk("reclust_phase", 32'(phase), 32'd1);
    chk("reclust_role", 32'(role), 32'd0);
    chk("reclust_hops", 32'(hopsFromSink), 32'd5);

    // member slot 2, TDMA window
    send(TS, 16'h000C, 16'd2);
    chk("slot", 32'(my_slot), 32'd2);
    send(DATA, 16'h0000, 16'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (tx_window) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
      tick();
    end
    chk("tx_first", 32'(first), 32'd128);
    chk("tx_last", 32'(last), 32'd191);
    chk("tx_count", 32'(cnt), 32'd64);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (130) tick();
    chk("tx_restart", 32'(tx_window), 32'd1);
    send(SOS, 16'h0000, 16'd0);
    chk("tx_sos_off", 32'(tx_window), 32'd0);
    chk("tx_sos_phase", 32'(phase), 32'd3);

    // HB timeout
    send(HB, 16'h0000, 16'd9);
    repeat (TO - 1) tick();
    chk("to_before", 32'(phase), 32'd1);
    tick();
    chk("to_phase", 32'(phase), 32'd0);
    chk("to_unlock", 32'(hb_lock), 32'd0);
    chk("to_hops_kept", 32'(hopsFromSink), 32'd9);

    // data on the expiry cycle wins
    send(HB, 16'h0000, 16'd4);
    repeat (TO - 1) tick();
    send(DATA, 16'h0000, 16'd0);
    chk("to_data_wins", 32'(phase), 32'd2);

    // synchronous reset mid-frame
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_phase", 32'(phase), 32'd0);
    chk("mrst_hops", 32'(hopsFromSink), 32'd0);
    chk("mrst_thr", 32'(eThreshold), 32'd0);
    chk("mrst_q", 32'(myQValue), 32'd0);
    chk("mrst_slot", 32'(my_slot), 32'd0);
    chk("mrst_tx", 32'(tx_window), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/node_info_ctrl.md
Name: node_info_ctrl

Overview:
Parametrised next-generation per-node information and phase controller for the EER-RL cluster node. It latches sink-distance, energy threshold and Q-value, and tracks node role through an explicit clustering-phase FSM. It adds an HB-lock timeout, SOS-driven reclustering, a hysteretic debounced low-energy flag, and a TDMA slot timer that drives the member transmit window. It sits beside the packet parser (which supplies en_MNI/fPktType/fields) and feeds the routing and TX logic.

Parameters:
WORD_W, 16, width of all ID/hop/energy/Q/slot fields
NODE_ID, 16'h000C, constant node identifier (WORD_W bits)
HB_TIMEOUT, 1024, cycles in S_CLUSTER without a data packet before lock auto-release (>=2)
SLOT_LEN, 64, clock cycles per TDMA slot (>=1)
E_HYST, 16, energy hysteresis added to threshold for low_E release
LOWE_CONFIRM, 4, consecutive below-threshold samples required to assert low_E (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en_MNI  in  1  parsed packet valid for this block, one cycle per packet
fPktType  in  3  000 HB, 001 CHE, 100 timeslot, 101 data, 110 SOS; others ignored
destinationID  in  WORD_W  packet destination
hops  in  WORD_W  hop count in HB
e_threshold  in  WORD_W  energy threshold carried in HB
timeslot  in  WORD_W  slot index in timeslot packet
energy  in  WORD_W  sensor energy reading
e_sample  in  1  energy reading valid strobe
q_valid  in  1  Q-value update strobe
q_value  in  WORD_W  new Q-value
frame_start  in  1  one-cycle pulse marking start of a TDMA frame
myNodeID  out  WORD_W  = NODE_ID
hopsFromSink  out  WORD_W  latched hop count
eThreshold  out  WORD_W  latched threshold
myQValue  out  WORD_W  latched Q-value
role  out  1  1 = cluster head
low_E  out  1  debounced low-energy flag
hb_lock  out  1  HB lock held
phase  out  2  FSM state encoding
my_slot  out  WORD_W  assigned TDMA slot
tx_window  out  1  high while current slot == my_slot
recluster_req  out  1  one-cycle pulse, CH entered low energy

Behaviour:
- Reset: all registered outputs 0; phase=S_UNCLUST; counters 0. Reset is honoured mid-operation in any state, so all in-flight timers and slots are discarded.
- "pkt(X)" means en_MNI=1 and fPktType=X. "toMe" means destinationID==NODE_ID.
- FSM:
  - S_UNCLUST=00. On pkt(HB) the HB is accepted: hopsFromSink<=hops, eThreshold<=e_threshold, role<=0, slot_valid<=0, hb_lock<=1, next S_CLUSTER.
  - S_CLUSTER=01. HB is ignored. pkt(CHE)&toMe sets role<=1. pkt(timeslot)&toMe&!role sets my_slot<=timeslot and slot_valid<=1. pkt(data) sets hb_lock<=0 and next S_COMM. The timeout counter increments each cycle. When it reaches HB_TIMEOUT-1 without pkt(data): hb_lock<=0, next S_UNCLUST, role and hop values retained. If pkt(data) occurs on that same cycle, S_COMM wins.
  - S_COMM=10. pkt(SOS) next S_RECLUST. pkt(HB) is ignored.
  - S_RECLUST=11. pkt(HB) is accepted exactly as in S_UNCLUST and next S_CLUSTER. frame_active is cleared.
- Timeout counter clears on every state entry and is active only in S_CLUSTER.
- Latency: every packet effect is visible on outputs the cycle after the en_MNI cycle.
- myQValue<=q_value when q_valid, in any state; otherwise it holds.
- low_E:
  - Evaluated only on e_sample.
  - If energy<eThreshold, a saturating confirm counter increments; otherwise it clears.
  - low_E sets on the sample that brings the count to LOWE_CONFIRM.
  - low_E clears on a sample with energy >= eThreshold+E_HYST. The sum saturates at all-ones.
  - Samples between the two bounds hold low_E.
- recluster_req: a one-cycle pulse on the 0->1 edge of low_E when role=1.
- TDMA:
  - frame_start in S_COMM sets frame_active=1 and clears cyc_cnt and slot_idx.
  - While frame_active, cyc_cnt counts 0..SLOT_LEN-1. On wrap, slot_idx increments, saturating at all-ones.
  - tx_window = frame_active & slot_valid & !role & (phase==S_COMM) & (slot_idx==my_slot). This is combinational from registers.
  - frame_start mid-frame restarts the frame.
  - Leaving S_COMM clears frame_active.
- Simultaneous events: a packet and frame_start in the same cycle are both applied. q_valid and e_sample are independent of packets.

Test Plan:
- Reset, then pkt(HB) with hops=3, e_threshold=100 -> next cycle hopsFromSink=3, eThreshold=100, hb_lock=1, phase=01. A second HB with hops=7 leaves hopsFromSink=3.
- In S_CLUSTER, pkt(CHE) with dest=000C, then pkt(data) -> role=1, phase=10, hb_lock=0. With dest=0005 instead -> role stays 0.
- Member path: timeslot=2 to 000C, data, then frame_start with SLOT_LEN=64 -> tx_window high exactly during cycles 128..191 after frame_start. It goes low after pkt(SOS).
- HB then idle for HB_TIMEOUT cycles -> phase=00 and hb_lock=0 at cycle HB_TIMEOUT. pkt(data) on the expiry cycle -> phase=10 instead.
- eThreshold=100, E_HYST=16, role=1, samples 90,90,90,90 -> low_E=1 after the 4th sample, with a recluster_req single pulse. Sample 110 -> low_E holds. Sample 116 -> low_E clears. The pattern 90,90,105,90 never sets low_E.
- In S_COMM, pkt(SOS) then pkt(HB) with hops=5 -> phase 11 then 01, role=0, hopsFromSink=5. Asserting rst mid-frame -> all outputs 0 on the next cycle.
